driver_scan_counter: RTL and testbench

Parametrised row-scan counter for the LED matrix driver. It replaces the fixed 0–4 crescent counter with a modulo-ROWS counter that supports:
- a clock prescaler
- up, down, ping-pong and hold modes
- synchronous load
- a wrap strobe

It produces both the binary row index and a one-hot row select, so it feeds the row drivers directly.

---
 rtl/driver_scan_pkg.sv | 15 +
 rtl/driver_row_decoder.sv | 19 +
 rtl/driver_scan_counter.sv | 111 +++++++++++
 tb/tb_driver_scan_counter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/driver_scan_pkg.sv
// Shared definitions for the LED matrix scan counters: mode encodings and the
// rule that derives a count width from a row count.
package driver_scan_pkg;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  // Smallest width that can hold 0..rows-1, never less than one bit.
  function automatic int unsigned scan_width(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/driver_row_decoder.sv
// Binary index to one-hot select decoder, shared by the row and column drivers.
module driver_row_decoder
  import driver_scan_pkg::*;
#(
  parameter int unsigned ROWS  = 5,
  parameter int unsigned WIDTH = scan_width(ROWS)
) (
  input  logic [WIDTH-1:0] bin_number_i,
  output logic [ROWS-1:0]  row_sel_o
);

  always_comb begin
    row_sel_o = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      row_sel_o[i] = (bin_number_i == WIDTH'(i));
    end
  end

endmodule

// File: rtl/driver_scan_counter.sv
// Modulo-ROWS row-scan counter with prescaler, up/down/ping-pong/hold modes,
// synchronous clamped load and a sequence-complete wrap strobe.
module driver_scan_counter
  import driver_scan_pkg::*;
#(
  parameter int unsigned ROWS  = 5,
  parameter int unsigned WIDTH = scan_width(ROWS),
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] bin_number,
  output logic [ROWS-1:0]  row_sel,
  output logic             tick,
  output logic             wrap
);

  localparam int unsigned      PreW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] MaxRow = WIDTH'(ROWS - 1);
  localparam logic [PreW-1:0]  PreMax = PreW'(DIV - 1);

  logic [WIDTH-1:0] bin_q, bin_d, step_val;
  logic [PreW-1:0]  pre_q, pre_d;
  logic             dir_q, dir_d, step_dir;  // dir: 1 = descending (ping-pong only)
  logic             boundary;

  // Candidate next count and direction if this cycle ticks.
  always_comb begin
    step_val = bin_q;
    step_dir = dir_q;
    boundary = 1'b0;
    unique case (mode)
      MODE_UP: begin
        boundary = (bin_q == MaxRow);
        step_val = boundary ? '0 : bin_q + 1'b1;
      end
      MODE_DOWN: begin
        boundary = (bin_q == '0);
        step_val = boundary ? MaxRow : bin_q - 1'b1;
      end
      MODE_PINGPONG: begin
        if (ROWS == 1) begin
          boundary = 1'b1;
        end else if (dir_q) begin
          boundary = (bin_q == '0);
          if (boundary) begin
            step_val = WIDTH'(1);
            step_dir = 1'b0;
          end else begin
            step_val = bin_q - 1'b1;
          end
        end else if (bin_q == MaxRow) begin
          step_val = WIDTH'(ROWS - 2);
          step_dir = 1'b1;
        end else begin
          step_val = bin_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign tick = en & (pre_q == PreMax) & ~rst & ~load;
  assign wrap = tick & boundary;

  always_comb begin
    bin_d = bin_q;
    dir_d = dir_q;
    pre_d = pre_q;
    if (load) begin
      bin_d = (load_value > MaxRow) ? MaxRow : load_value;
      dir_d = 1'b0;
      pre_d = '0;
    end else begin
      if (en) begin
        pre_d = tick ? '0 : pre_q + 1'b1;
      end
      if (tick) begin
        bin_d = step_val;
        dir_d = step_dir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      dir_q <= 1'b0;
      pre_q <= '0;
    end else begin
      bin_q <= bin_d;
      dir_q <= dir_d;
      pre_q <= pre_d;
    end
  end

  assign bin_number = bin_q;

  driver_row_decoder #(
    .ROWS  (ROWS),
    .WIDTH (WIDTH)
  ) u_row_decoder (
    .bin_number_i (bin_q),
    .row_sel_o    (row_sel)
  );

endmodule

// File: tb/tb_driver_scan_counter.sv
// Scoreboard bench: two counters (DIV=1 and DIV=3, ROWS=5) share one stimulus
// stream; a reference model queues expected outputs, a monitor compares them.
module tb_driver_scan_counter;
  import driver_scan_pkg::*;

  localparam int R = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] lv = 3'd0;

  logic [2:0] bin0, bin1;
  logic [4:0] row0, row1;
  logic       tick0, tick1, wrap0, wrap1;

  always #5 clk = ~clk;

  driver_scan_counter #(.ROWS(5), .WIDTH(3), .DIV(1)) u_dut_div1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_value(lv),
    .bin_number(bin0), .row_sel(row0), .tick(tick0), .wrap(wrap0)
  );

  driver_scan_counter #(.ROWS(5), .WIDTH(3), .DIV(3)) u_dut_div3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_value(lv),
    .bin_number(bin1), .row_sel(row1), .tick(tick1), .wrap(wrap1)
  );

  typedef struct packed {
    logic [2:0] bin;
    logic [4:0] row;
    logic       tick;
    logic       wrap;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state: row index, descending flag, enabled cycles into the period.
  int m_bin[2] = '{0, 0};
  int m_dir[2] = '{0, 0};
  int m_pre[2] = '{0, 0};
  int divs[2]  = '{1, 3};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // Ping-pong is treated as a walk around a ring of 2*(R-1) phases.
  task automatic model_step(input int k, output exp_t e);
    int   b, d, p, ph;
    logic t, w;
    b = m_bin[k];
    d = m_dir[k];
    p = m_pre[k];
    t = !rst && !load && en && (p == divs[k] - 1);
    case (mode)
      2'b00:   w = t && (b == R - 1);
      2'b01:   w = t && (b == 0);
      2'b10:   w = t && (d == 1) && (b == 0);
      default: w = 1'b0;
    endcase
    e.bin  = b[2:0];
    e.row  = 5'(1 << b);
    e.tick = t;
    e.wrap = w;
    if (rst) begin
      b = 0; d = 0; p = 0;
    end else if (load) begin
      b = (int'(lv) > R - 1) ? R - 1 : int'(lv);
      d = 0; p = 0;
    end else begin
      if (en) p = t ? 0 : p + 1;
      if (t) begin
        case (mode)
          2'b00: b = (b + 1) % R;
          2'b01: b = (b + R - 1) % R;
          2'b10: begin
            ph = (d == 1) ? (2 * R - 2 - b) : b;
            ph = (ph + 1) % (2 * R - 2);
            b  = (ph < R) ? ph : 2 * R - 2 - ph;
            d  = (ph >= R || ph == 0) ? 1 : 0;
          end
          default: ;
        endcase
      end
    end
    m_bin[k] = b;
    m_dir[k] = d;
    m_pre[k] = p;
  endtask

  task automatic step(input logic r, input logic e_, input logic ld, input logic [1:0] md,
                      input logic [2:0] v);
    exp_t x;
    @(posedge clk);
    #1;
    rst  = r;
    en   = e_;
    load = ld;
    mode = md;
    lv   = v;
    model_step(0, x);
    q0.push_back(x);
    model_step(1, x);
    q1.push_back(x);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("div1_bin", 32'(bin0), 32'(e.bin));
        chk("div1_row_sel", 32'(row0), 32'(e.row));
        chk("div1_tick", 32'(tick0), 32'(e.tick));
        chk("div1_wrap", 32'(wrap0), 32'(e.wrap));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("div3_bin", 32'(bin1), 32'(e.bin));
        chk("div3_row_sel", 32'(row1), 32'(e.row));
        chk("div3_tick", 32'(tick1), 32'(e.tick));
        chk("div3_wrap", 32'(wrap1), 32'(e.wrap));
      end
    end
  end

  initial begin : stimulus
    logic       r, ld, e_;
    logic [1:0] md;
    logic [2:0] v;
    int         guard;

    step(1'b1, 1'b0, 1'b0, MODE_UP, 3'd0);
    step(1'b1, 1'b1, 1'b1, MODE_PINGPONG, 3'd3);          // reset beats load
    repeat (16) step(1'b0, 1'b1, 1'b0, MODE_UP, 3'd0);
    repeat (4) step(1'b0, 1'b1, 1'b0, MODE_UP, 3'd0);
    repeat (2) step(1'b0, 1'b0, 1'b0, MODE_UP, 3'd0);      // en gap mid-period
    repeat (7) step(1'b0, 1'b1, 1'b0, MODE_UP, 3'd0);
    step(1'b1, 1'b1, 1'b1, MODE_PINGPONG, 3'd5);
    repeat (30) step(1'b0, 1'b1, 1'b0, MODE_PINGPONG, 3'd0);
    step(1'b0, 1'b1, 1'b1, MODE_UP, 3'd7);                 // load during tick, clamped
    repeat (3) step(1'b0, 1'b1, 1'b0, MODE_UP, 3'd0);
    step(1'b0, 1'b0, 1'b1, MODE_UP, 3'd2);                 // load with en low
    repeat (2) step(1'b0, 1'b0, 1'b0, MODE_UP, 3'd0);
    step(1'b0, 1'b1, 1'b1, MODE_DOWN, 3'd0);
    repeat (16) step(1'b0, 1'b1, 1'b0, MODE_DOWN, 3'd0);
    repeat (9) step(1'b0, 1'b1, 1'b0, MODE_HOLD, 3'd0);

    md = MODE_PINGPONG;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      ld = ($urandom_range(0, 11) == 0);
      e_ = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 7) == 0) md = 2'($urandom_range(0, 3));
      v  = 3'($urandom_range(0, 7));
      step(r, e_, ld, md, v);
    end

    guard = 0;
    while ((q0.size() + q1.size()) != 0 && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("scoreboard_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
